// File: rtl/halt_dump_unit.sv
// End-of-run controller: halts `machine` on a zero instruction or cycle budget,
// then streams PC, the 32 registers and a data-memory window over valid/ready.
module halt_dump_unit #(
  parameter int          MAX_CYCLES = 64,
  parameter logic [31:0] MEM_BASE   = 32'h4000,
  parameter int          MEM_COUNT  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] inst,
  input  logic [31:0] pc,
  output logic        halt,
  output logic [4:0]  rf_raddr,
  input  logic [31:0] rf_rdata,
  output logic [31:0] mem_raddr,
  input  logic [7:0]  mem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [1:0]  out_tag,
  output logic        out_last,
  output logic [31:0] cycle_count,
  output logic [1:0]  halt_cause,
  output logic        done
);

  typedef enum logic [2:0] {
    S_RUN,
    S_DUMP_PC,
    S_DUMP_REG,
    S_DUMP_MEM,
    S_DONE
  } state_e;

  localparam logic [31:0] BUDGET   = 32'(MAX_CYCLES);
  localparam logic [31:0] LAST_IDX = 32'(MEM_COUNT - 1);

  state_e      state_q, state_d;
  logic [31:0] cycle_count_q, cycle_count_d;
  logic [31:0] pc_snap_q, pc_snap_d;
  logic [31:0] idx_q, idx_d;
  logic [1:0]  cause_q, cause_d;

  logic zero_inst, timeout, trigger;

  assign zero_inst   = (inst == 32'd0);
  assign timeout     = (cycle_count_q == BUDGET);
  assign trigger     = zero_inst | timeout;
  assign cycle_count = cycle_count_q;
  assign halt_cause  = cause_q;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_RUN;
      cycle_count_q <= '0;
      pc_snap_q     <= '0;
      idx_q         <= '0;
      cause_q       <= 2'd0;
    end else begin
      state_q       <= state_d;
      cycle_count_q <= cycle_count_d;
      pc_snap_q     <= pc_snap_d;
      idx_q         <= idx_d;
      cause_q       <= cause_d;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d       = state_q;
    cycle_count_d = cycle_count_q;
    pc_snap_d     = pc_snap_q;
    idx_d         = idx_q;
    cause_d       = cause_q;
    halt          = 1'b1;
    out_valid     = 1'b0;
    out_data      = '0;
    out_tag       = 2'd0;
    out_last      = 1'b0;
    rf_raddr      = '0;
    mem_raddr     = MEM_BASE;
    done          = 1'b0;

    case (state_q)
      S_RUN: begin
        // Combinational halt keeps the triggering instruction from committing.
        halt = trigger;
        if (trigger) begin
          pc_snap_d = pc;
          cause_d   = zero_inst ? 2'd1 : 2'd2;
          state_d   = S_DUMP_PC;
        end else if (cycle_count_q != 32'hFFFF_FFFF) begin
          cycle_count_d = cycle_count_q + 32'd1;
        end
      end
      S_DUMP_PC: begin
        out_valid = 1'b1;
        out_data  = pc_snap_q;
        out_tag   = 2'd0;
        if (out_ready) begin
          idx_d   = '0;
          state_d = S_DUMP_REG;
        end
      end
      S_DUMP_REG: begin
        out_valid = 1'b1;
        rf_raddr  = idx_q[4:0];
        out_data  = rf_rdata;
        out_tag   = 2'd1;
        if (out_ready) begin
          if (idx_q[4:0] == 5'd31) begin
            idx_d   = '0;
            state_d = S_DUMP_MEM;
          end else begin
            idx_d = idx_q + 32'd1;
          end
        end
      end
      S_DUMP_MEM: begin
        out_valid = 1'b1;
        mem_raddr = MEM_BASE + idx_q;
        out_data  = {24'd0, mem_rdata};
        out_tag   = 2'd2;
        out_last  = (idx_q == LAST_IDX);
        if (out_ready) begin
          if (idx_q == LAST_IDX) state_d = S_DONE;
          else                   idx_d   = idx_q + 32'd1;
        end
      end
      S_DONE: begin
        done = 1'b1;
      end
      default: state_d = S_RUN;
    endcase

    if (reset) halt = 1'b0;
  end

endmodule

// File: tb/tb_halt_dump_unit.sv
// Randomized bench for halt_dump_unit: a small fake `machine` plus a
// transaction-level model of the expected halt point and dump stream.
module tb_halt_dump_unit;

  localparam int          MAX_CYCLES = 64;
  localparam logic [31:0] MEM_BASE   = 32'h4000;
  localparam int          MEM_COUNT  = 4;
  localparam int          NBEATS     = 33 + MEM_COUNT;
  localparam logic [31:0] PC0        = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] inst, pc;
  logic        halt;
  logic [4:0]  rf_raddr;
  logic [31:0] rf_rdata;
  logic [31:0] mem_raddr;
  logic [7:0]  mem_rdata;
  logic        out_valid, out_ready, out_last, done;
  logic [31:0] out_data, cycle_count;
  logic [1:0]  out_tag, halt_cause;

  halt_dump_unit #(
    .MAX_CYCLES(MAX_CYCLES), .MEM_BASE(MEM_BASE), .MEM_COUNT(MEM_COUNT)
  ) dut (
    .clk(clk), .reset(reset), .inst(inst), .pc(pc), .halt(halt),
    .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
    .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_tag(out_tag), .out_last(out_last), .cycle_count(cycle_count),
    .halt_cause(halt_cause), .done(done)
  );

  always #5 clk = ~clk;

  // Fake machine: each nonzero instruction writes itself into r[inst[11:7]].
  logic [31:0] rf_init [32];
  logic [31:0] rf [32];
  logic [7:0]  mem_bytes [4];
  logic [31:0] mem_off;

  always @(posedge clk) begin
    if (reset) begin
      for (int j = 0; j < 32; j++) rf[j] <= rf_init[j];
    end else if (!halt && inst != 32'd0 && inst[11:7] != 5'd0) begin
      rf[inst[11:7]] <= inst;
    end
  end

  assign rf_rdata = rf[rf_raddr];
  assign mem_off  = mem_raddr - MEM_BASE;
  always_comb begin
    mem_rdata = 8'h00;
    if (mem_off < 32'(MEM_COUNT)) mem_rdata = mem_bytes[mem_off[1:0]];
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model state shared with the compare process.
  logic [31:0] exp_beats [NBEATS];
  logic [31:0] got [NBEATS];
  logic [1:0]  exp_cause;
  int          k, cur_i, beat;
  bit          checking, in_dump, prev_stall;
  logic [31:0] prev_data, prev_mem;
  logic [4:0]  prev_rf;

  always @(negedge clk) begin
    if (checking && !reset) begin
      if (!in_dump) begin
        check("run_halt", 32'(halt), 32'(cur_i == k));
        check("run_cycle_count", cycle_count, 32'(cur_i));
        check("run_out_valid", 32'(out_valid), 32'd0);
        check("run_out_last", 32'(out_last), 32'd0);
        check("run_halt_cause", 32'(halt_cause), 32'd0);
        check("run_done", 32'(done), 32'd0);
        check("run_rf_raddr", 32'(rf_raddr), 32'd0);
        check("run_mem_raddr", mem_raddr, MEM_BASE);
      end else begin
        check("dump_halt", 32'(halt), 32'd1);
        check("dump_cycle_count", cycle_count, 32'(k));
        check("dump_halt_cause", 32'(halt_cause), 32'(exp_cause));
        if (beat < NBEATS) begin
          check("beat_valid", 32'(out_valid), 32'd1);
          check("beat_done", 32'(done), 32'd0);
          check("beat_data", out_data, exp_beats[beat]);
          check("beat_tag", 32'(out_tag), (beat == 0) ? 32'd0 : (beat <= 32) ? 32'd1 : 32'd2);
          check("beat_last", 32'(out_last), 32'(beat == NBEATS - 1));
          if (beat >= 1 && beat <= 32) check("beat_rf_raddr", 32'(rf_raddr), 32'(beat - 1));
          if (beat >= 33) check("beat_mem_raddr", mem_raddr, MEM_BASE + 32'(beat - 33));
          if (prev_stall) begin
            check("stall_data", out_data, prev_data);
            check("stall_rf_raddr", 32'(rf_raddr), 32'(prev_rf));
            check("stall_mem_raddr", mem_raddr, prev_mem);
          end
          prev_stall = !out_ready;
          prev_data  = out_data;
          prev_rf    = rf_raddr;
          prev_mem   = mem_raddr;
          if (out_ready) begin
            got[beat] = out_data;
            beat++;
          end
        end else begin
          check("done_valid", 32'(out_valid), 32'd0);
          check("done_flag", 32'(done), 32'd1);
          check("done_last", 32'(out_last), 32'd0);
        end
      end
    end
  end

  // One run: reset, execute the sequence until halt, then drain (or abort) the dump.
  task automatic run_scenario(input int n_nonzero, input bit use_zero, input int ready_mode,
                              input int abort_at, input bit contents);
    logic [31:0] seq [$];
    logic [31:0] exp_rf [32];
    logic [31:0] v;
    int cyc;

    for (int j = 0; j < 32; j++) rf_init[j] = (j == 0) ? 32'd0 : $urandom;
    for (int j = 0; j < 4; j++) mem_bytes[j] = 8'($urandom);
    if (contents) begin
      rf_init[3]   = 32'h0040_002C;
      mem_bytes[2] = 8'hAB;
    end

    seq.delete();
    for (int i = 0; i < n_nonzero; i++) begin
      v = $urandom | 32'h1;
      if (contents && v[11:7] == 5'd3) v[7] = 1'b0;
      seq.push_back(v);
    end
    if (use_zero) seq.push_back(32'd0);

    // Halt point: first zero instruction or the budget, whichever comes first.
    k = -1;
    for (int i = 0; i < seq.size(); i++)
      if (k < 0 && (seq[i] == 32'd0 || i == MAX_CYCLES)) k = i;
    exp_cause = (seq[k] == 32'd0) ? 2'd1 : 2'd2;
    for (int j = 0; j < 32; j++) exp_rf[j] = rf_init[j];
    for (int i = 0; i < k; i++) if (seq[i][11:7] != 5'd0) exp_rf[seq[i][11:7]] = seq[i];
    exp_beats[0] = PC0 + 32'(4 * k);
    for (int j = 0; j < 32; j++) exp_beats[1 + j] = exp_rf[j];
    for (int j = 0; j < MEM_COUNT; j++) exp_beats[33 + j] = {24'd0, mem_bytes[j]};

    checking = 0; in_dump = 0; beat = 0; prev_stall = 0;
    reset = 1'b1;
    inst  = 32'd0;
    @(posedge clk); #1;
    @(negedge clk);
    check("reset_halt_forced_low", 32'(halt), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    cur_i = 0;
    inst  = seq[0];
    pc    = PC0;
    checking = 1;

    forever begin
      @(posedge clk); #1;
      if (cur_i == k) break;
      cur_i++;
      inst      = seq[cur_i];
      pc        = PC0 + 32'(4 * cur_i);
      out_ready = 1'($urandom);
    end
    in_dump = 1;

    cyc = 0;
    while (beat < NBEATS && cyc < 400) begin
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (cyc % 3 == 0);
        default: out_ready = 1'($urandom);
      endcase
      @(posedge clk); #1;
      cyc++;
      if (abort_at >= 0 && beat == abort_at) break;
    end
    check("dump_within_budget", 32'(cyc < 400), 32'd1);

    if (abort_at >= 0) begin
      checking = 0;
      reset    = 1'b1;
      @(negedge clk);
      check("abort_halt", 32'(halt), 32'd0);
      @(posedge clk); #1;
      @(negedge clk);
      check("abort_out_valid", 32'(out_valid), 32'd0);
      check("abort_out_last", 32'(out_last), 32'd0);
      check("abort_cycle_count", cycle_count, 32'd0);
      check("abort_done", 32'(done), 32'd0);
      check("abort_halt_cause", 32'(halt_cause), 32'd0);
      return;
    end

    repeat (2) begin
      out_ready = 1'($urandom);
      @(posedge clk); #1;
    end
    checking = 0;
    check("beat_count", 32'(beat), 32'(NBEATS));
  endtask

  initial begin
    reset = 1'b1; inst = 32'd0; pc = 32'd0; out_ready = 1'b0;
    checking = 0; in_dump = 0; beat = 0;

    // Zero-instruction halt with known contents.
    run_scenario(5, 1, 0, -1, 1);
    check("zi_cycle_count", cycle_count, 32'd5);
    check("zi_cause", 32'(halt_cause), 32'd1);
    check("zi_beat0_pc", got[0], 32'h0040_0014);
    check("zi_beat4_r3", got[4], 32'h0040_002C);
    check("zi_beat35_byte", got[35], 32'h0000_00AB);

    // Timeout at the 65th RUN cycle.
    run_scenario(MAX_CYCLES + 1, 0, 0, -1, 0);
    check("to_cycle_count", cycle_count, 32'd64);
    check("to_cause", 32'(halt_cause), 32'd2);

    // Backpressure: ready one cycle in three.
    run_scenario(9, 1, 1, -1, 0);

    // Reset after beat 10, then a clean rerun.
    run_scenario(7, 1, 0, 11, 0);
    run_scenario(3, 1, 0, -1, 1);
    check("rerun_beat0_pc", got[0], 32'h0040_000C);

    // Zero instruction exactly at the budget: zero cause wins.
    run_scenario(MAX_CYCLES, 1, 2, -1, 0);
    check("sim_cause", 32'(halt_cause), 32'd1);
    check("sim_cycle_count", cycle_count, 32'd64);

    // Immediate halt on the first cycle out of reset.
    run_scenario(0, 1, 2, -1, 0);

    for (int s = 0; s < 4; s++) begin
      int n;
      n = $urandom_range(0, 70);
      run_scenario(n, (n <= MAX_CYCLES) ? 1'b1 : 1'($urandom), 2, -1, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/halt_dump_unit.md
# halt_dump_unit

Synthesizable end-of-run controller that sits directly downstream of `machine`. It watches the executing instruction and a cycle budget, and freezes the datapath on a halt condition. It then streams the architectural state out through a valid/ready port: the captured PC, all 32 registers, and a window of data memory. It replaces bench-only state dumping, so the same run/dump flow works on hardware and in simulation.

## Interface
- `MAX_CYCLES`, default 64: committed-instruction budget before a timeout halt.
- `MEM_BASE`, default 32'h4000: first data-memory byte address dumped.
- `MEM_COUNT`, default 4: number of memory bytes dumped (≥1).
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `inst` in 32: instruction currently executing in `machine`.
- `pc` in 32: byte PC of `inst`.
- `halt` out 1: freeze request to `machine`. Blocks PC, register-file and memory writes while high.
- `rf_raddr` out 5: dump read address into the register file.
- `rf_rdata` in 32: combinational read data for `rf_raddr`.
- `mem_raddr` out 32: dump byte address into data memory.
- `mem_rdata` in 8: combinational read data for `mem_raddr`.
- `out_valid` out 1, `out_ready` in 1: dump stream handshake.
- `out_data` out 32: dump word.
- `out_tag` out 2: 0 = PC, 1 = register, 2 = memory byte.
- `out_last` out 1: marks the final beat.
- `cycle_count` out 32: committed-instruction count.
- `halt_cause` out 2: 0 = none, 1 = zero instruction, 2 = timeout.
- `done` out 1: dump complete (sticky).

## Operation
- FSM states: RUN, DUMP_PC, DUMP_REG, DUMP_MEM, DONE.
- **RUN**
  - trigger = (`inst` == 0) OR (`cycle_count` == `MAX_CYCLES`).
  - If both conditions hold, the zero-instruction cause wins (`halt_cause` = 1).
  - No trigger: `cycle_count` increments by 1, saturating at 2^32−1.
  - Trigger: latch `pc` into `pc_snap`, latch `halt_cause`, go to DUMP_PC. `cycle_count` freezes.
- **halt** = (state ≠ RUN) OR (state == RUN AND trigger). It is combinational, so the triggering instruction never commits.
- **DUMP_PC**: `out_data` = `pc_snap`, tag 0. On handshake, go to DUMP_REG with index 0.
- **DUMP_REG**
  - `rf_raddr` = index; `out_data` = `rf_rdata`; tag 1.
  - Each handshake increments index.
  - The handshake at index 31 goes to DUMP_MEM with index 0.
- **DUMP_MEM**
  - `mem_raddr` = `MEM_BASE` + index; `out_data` = {24'b0, `mem_rdata`}; tag 2.
  - `out_last` = 1 at index `MEM_COUNT`−1.
  - The handshake on the last beat goes to DONE.
- **DONE**: `out_valid` = 0, `done` = 1, `halt` = 1. Held until reset.
- Total beats = 33 + `MEM_COUNT` (37 at defaults).

## Timing
- Reset values (the edge with `reset` high):
  - state = RUN; `cycle_count` = 0; `halt_cause` = 0; `done` = 0; `out_valid` = 0; `out_last` = 0.
  - `rf_raddr` = 0; `mem_raddr` = `MEM_BASE`; `pc_snap` = 0.
  - `halt` is forced to 0 while `reset` is high.
- `halt` rises in the same cycle the trigger is seen. DUMP_PC begins on the next edge.
- `out_valid` is high in all DUMP states. A transfer occurs on a rising edge with `out_valid` AND `out_ready`.
- While `out_valid` is high and `out_ready` is low, `out_data`, `out_tag`, `out_last` and the read addresses hold stable.
- With `out_ready` held high, one beat per cycle: DONE is entered 37 cycles after DUMP_PC entry (defaults).
- `rf_rdata` and `mem_rdata` are combinational with zero latency. The data is stable because `machine` is frozen.
- Reset mid-dump: the stream is aborted and `out_valid` is 0 after the reset edge. No `out_last` is emitted and `done` stays 0. The next halt produces a full stream starting from the PC beat.
- `cycle_count` counts RUN cycles that end without a trigger. With `MAX_CYCLES` = 64, the timeout fires on the 65th RUN cycle, when `cycle_count` = 64.

## Test plan
- **Zero-instruction halt.** Reset 2 cycles; 5 nonzero `inst`; then `inst` = 0 at `pc` = 0x00400014; `out_ready` = 1.
  - `halt` = 1 the same cycle; `halt_cause` = 1; `cycle_count` = 5.
  - 37 beats: beat 0 = 0x00400014 with tag 0; beat 36 has tag 2 and `out_last`.
  - `done` = 1 the following cycle.
- **Timeout.** `inst` never 0, `MAX_CYCLES` = 64 → trigger at `cycle_count` = 64 with `halt_cause` = 2. No register write commits after trigger.
- **Contents.** Model r[3] = 0x0040002C and byte[0x4002] = 0xAB → beat 4 = 0x0040002C (tag 1); beat 35 = 0x000000AB (tag 2).
- **Backpressure.** `out_ready` high 1 cycle in 3 → outputs stable during stalls; still exactly 37 beats in order; `out_last` only on the final beat.
- **Reset mid-dump.** Assert `reset` after beat 10 → `out_valid` = 0, `cycle_count` = 0, `done` = 0, `halt` = 0. Rerun to a zero-instruction halt → full 37-beat stream.
- **Simultaneous causes.** `inst` = 0 in the cycle where `cycle_count` = `MAX_CYCLES` → `halt_cause` = 1.
